alu_pipe: RTL

Parametrised, pipelined successor to the team's small 4-bit clocked ALU. It is generalised in data width and extended to eight operations, status flags, optional signed saturation, and valid/ready handshakes on both sides with backpressure. It sits between an operand producer and a result consumer in the ALU verification testbenches, and also serves as a reusable datapath block.

---
 rtl/alu_pipe.sv | 110 +++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage pipelined ALU with valid/ready handshakes, status flags and optional saturation
// S1 holds the raw operands, S2 holds the computed result; both stages advance together when the output slot frees.
module alu_pipe #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] txn_count
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic             s1_valid_q, s2_valid_q;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] cnt_q;
    logic             adv;

    logic [WIDTH:0]   sum, diff, shl, shr;
    logic [SW-1:0]    amt;
    logic             c, v;

    assign adv       = !s2_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = s2_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;
    assign txn_count = cnt_q;

    // The extra top/bottom bit of each wide vector captures carry, borrow or the last bit shifted out.
    always_comb begin
        amt      = b_q[SW-1:0];
        sum      = {1'b0, a_q} + {1'b0, b_q};
        diff     = {1'b0, a_q} - {1'b0, b_q};
        shl      = {1'b0, a_q} << amt;
        shr      = {a_q, 1'b0} >> amt;
        result_d = '0;
        c        = 1'b0;
        v        = 1'b0;
        case (op_q)
            3'b000: begin
                result_d = sum[WIDTH-1:0];
                c        = sum[WIDTH];
                v        = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (result_d[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'b001: begin
                result_d = diff[WIDTH-1:0];
                c        = diff[WIDTH];
                v        = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (result_d[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'b010: result_d = a_q & b_q;
            3'b011: result_d = a_q | b_q;
            3'b100: result_d = a_q ^ b_q;
            3'b101: begin
                result_d = shl[WIDTH-1:0];
                c        = shl[WIDTH];
            end
            3'b110: begin
                result_d = shr[WIDTH:1];
                c        = shr[0];
            end
            default: result_d = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
        endcase
        // Overflow is only ever raised by ADD/SUB, so the clamp cannot touch other ops.
        if (SATURATE && v) begin
            result_d = a_q[WIDTH-1] ? SMIN : SMAX;
        end
        flags_d = {v, result_d[WIDTH-1], (result_d == '0), c};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            flags_q    <= '0;
            cnt_q      <= '0;
        end else begin
            if (adv) begin
                result_q   <= result_d;
                flags_q    <= flags_d;
                s2_valid_q <= s1_valid_q;
                a_q        <= a;
                b_q        <= b;
                op_q       <= op;
                s1_valid_q <= in_valid;
            end
            if (s2_valid_q && out_ready) begin
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end
endmodule
